// File: rtl/img_pkg.sv
// Shared definitions for the image path: loader FSM states and header byte offsets.
// The optional checksum trailer (macro IMG_LOADER_CHECKSUM_EN) adds the ST_CHECK state.
package img_pkg;

  localparam int HDR_WIDTH_HI  = 0;
  localparam int HDR_WIDTH_LO  = 1;
  localparam int HDR_HEIGHT_HI = 4;
  localparam int HDR_HEIGHT_LO = 5;
  localparam int HDR_LEN       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_SIZE,
    ST_PIXELS,
`ifdef IMG_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/img_loader.sv
// Streams one image file (header + grayscale pixels) into display RAM and validates its size.
// Optional XOR trailer check is enabled by defining IMG_LOADER_CHECKSUM_EN.
module img_loader
  import img_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int MEM_DEPTH    = 262144,
  parameter int BASE_ADDRESS = HDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        wrdata,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_e    state, state_nx;
  logic [CNT_W-1:0] count;
  logic [31:0]      remaining;
  logic [7:0]       width_hi, height_hi;
  logic [31:0]      area;
  logic [32:0]      total;
  logic             size_bad;
  logic             accept;
  logic             start_ok;
  logic             store;
`ifdef IMG_LOADER_CHECKSUM_EN
  logic [7:0]       xor_acc;
`endif

  // Full-width product so oversize images cannot alias into range.
  always_comb begin
    area     = 32'(img_width) * 32'(img_height);
    total    = {1'b0, area} + 33'(BASE_ADDRESS);
    size_bad = (img_width == 16'd0) || (img_height == 16'd0) || (total > 33'(MEM_DEPTH));
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    start_ok = 1'b0;
    store    = 1'b0;
    unique case (state)
      ST_IDLE:   start_ok = start;
      ST_HEADER: begin in_ready = 1'b1; busy = 1'b1; store = 1'b1; end
      ST_SIZE:   busy = 1'b1;
      ST_PIXELS: begin in_ready = 1'b1; busy = 1'b1; store = 1'b1; end
`ifdef IMG_LOADER_CHECKSUM_EN
      ST_CHECK:  begin in_ready = 1'b1; busy = 1'b1; end
`endif
      ST_DONE:   begin done = 1'b1; start_ok = start; end
      ST_ERROR:  begin error = 1'b1; start_ok = start; end
      default:   ;
    endcase
    accept = in_valid && in_ready;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (start) state_nx = ST_HEADER;
      ST_HEADER:
        if (accept && count == CNT_W'(BASE_ADDRESS - 1)) state_nx = ST_SIZE;
      ST_SIZE:
        state_nx = size_bad ? ST_ERROR : ST_PIXELS;
      ST_PIXELS:
        if (accept && remaining == 32'd1) begin
`ifdef IMG_LOADER_CHECKSUM_EN
          state_nx = ST_CHECK;
`else
          state_nx = ST_DONE;
`endif
        end
`ifdef IMG_LOADER_CHECKSUM_EN
      ST_CHECK:
        if (accept) state_nx = (in_data == xor_acc) ? ST_DONE : ST_ERROR;
`endif
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Write port, byte counter, header decode and pixel countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wraddress  <= '0;
      wrdata     <= '0;
      wren       <= 1'b0;
      count      <= '0;
      remaining  <= '0;
      width_hi   <= '0;
      height_hi  <= '0;
      img_width  <= '0;
      img_height <= '0;
`ifdef IMG_LOADER_CHECKSUM_EN
      xor_acc    <= '0;
`endif
    end else begin
      wren <= 1'b0;
      if (start_ok) begin
        count      <= '0;
        img_width  <= '0;
        img_height <= '0;
`ifdef IMG_LOADER_CHECKSUM_EN
        xor_acc    <= '0;
`endif
      end
      if (accept && store) begin
        wraddress <= count[ADDR_W-1:0];
        wrdata    <= in_data;
        wren      <= 1'b1;
        count     <= count + 1'b1;
      end
      if (accept && state == ST_HEADER) begin
        if (count == CNT_W'(HDR_WIDTH_HI))  width_hi   <= in_data;
        if (count == CNT_W'(HDR_WIDTH_LO))  img_width  <= {width_hi, in_data};
        if (count == CNT_W'(HDR_HEIGHT_HI)) height_hi  <= in_data;
        if (count == CNT_W'(HDR_HEIGHT_LO)) img_height <= {height_hi, in_data};
      end
      if (state == ST_SIZE && !size_bad) remaining <= area;
      if (accept && state == ST_PIXELS) begin
        remaining <= remaining - 32'd1;
`ifdef IMG_LOADER_CHECKSUM_EN
        xor_acc   <= xor_acc ^ in_data;
`endif
      end
    end
  end

endmodule
